// File: rtl/prime_range_engine.sv
// prime_range_engine
//   Scans the inclusive range [NumMin, NumMax] and tests each candidate by
//   trial division with odd divisors 3, 5, 7, ... until d*d > n. Each trial
//   runs a restoring shift-subtract division that produces one quotient bit
//   per clock, so the design contains no combinational modulus operator.
//   Each prime is offered on a valid/ready stream, and running statistics
//   are kept alongside the stream.
//
//   Optional build macro: PRIME_CYCLE_COUNT_EN. When it is defined,
//   CycleCount counts the clocks spent busy and saturates at all-ones.
//   When it is not defined, CycleCount is tied to 0.
//
// Ports
//   SysClk        rising-edge clock
//   Reset_n       asynchronous active-low reset
//   Start         run request, accepted only in IDLE or DONE
//   NumMin/NumMax inclusive range bounds, latched when Start is accepted
//   Busy / Done   run in progress / run finished (Done holds until next Start)
//   PrimeValid / PrimeReady / PrimeNum   prime output stream
//   PrimeCount    primes transferred in this run (saturating)
//   NumberChecked current or last candidate
//   CycleCount    clocks spent busy since the accepted Start (optional)
module prime_range_engine #(
  parameter int NUM_W = 10,
  parameter int CNT_W = 8,
  parameter int CYC_W = 24
) (
  input  logic             SysClk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [NUM_W-1:0] NumMin,
  input  logic [NUM_W-1:0] NumMax,
  output logic             Busy,
  output logic             Done,
  output logic             PrimeValid,
  input  logic             PrimeReady,
  output logic [NUM_W-1:0] PrimeNum,
  output logic [CNT_W-1:0] PrimeCount,
  output logic [NUM_W-1:0] NumberChecked,
  output logic [CYC_W-1:0] CycleCount
);

  localparam int BIT_W = $clog2(NUM_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SQCHK, S_DIV, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_W-1:0]   min_q, min_d, max_q, max_d;
  logic [NUM_W-1:0]   n_q, n_d;
  logic [NUM_W-1:0]   dvd_q, dvd_d;
  logic [NUM_W:0]     d_q, d_d;
  logic [NUM_W:0]     rem_q, rem_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               start_ok;
  logic [NUM_W-1:0]   first_n;
  logic [2*NUM_W+1:0] d_sq;
  logic [NUM_W+1:0]   rem_shift;
  logic [NUM_W:0]     rem_next;

  assign start_ok = Start && (state_q == S_IDLE || state_q == S_DONE);
  // The first candidate is never below 2: 0 and 1 are not prime.
  assign first_n  = (min_q < NUM_W'(2)) ? NUM_W'(2) : min_q;
  // The square is formed at full width, so the comparison cannot wrap.
  assign d_sq     = {{(NUM_W+1){1'b0}}, d_q} * {{(NUM_W+1){1'b0}}, d_q};

  // One restoring-division step. The partial remainder stays below d,
  // so after the shift it fits in NUM_W+2 bits and after the subtract
  // it fits back into NUM_W+1 bits.
  assign rem_shift = {rem_q, dvd_q[NUM_W-1]};
  assign rem_next  = (rem_shift >= {1'b0, d_q})
                   ? (NUM_W+1)'(rem_shift - {1'b0, d_q})
                   : rem_shift[NUM_W:0];

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    n_d     = n_q;
    dvd_d   = dvd_q;
    d_d     = d_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          min_d   = NumMin;
          max_d   = NumMax;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (max_q < first_n) begin
          state_d = S_DONE;
        end else begin
          n_d     = first_n;
          d_d     = (NUM_W+1)'(3);
          state_d = S_SQCHK;
        end
      end
      S_SQCHK: begin
        if (n_q == NUM_W'(2)) begin
          state_d = S_EMIT;
        end else if (!n_q[0]) begin
          state_d = S_NEXT;
        end else if (d_sq > {{(NUM_W+2){1'b0}}, n_q}) begin
          state_d = S_EMIT;
        end else begin
          rem_d   = '0;
          dvd_d   = n_q;
          bit_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        dvd_d = dvd_q << 1;
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(NUM_W - 1)) begin
          if (rem_next == '0) begin
            state_d = S_NEXT;
          end else begin
            d_d     = d_q + (NUM_W+1)'(2);
            state_d = S_SQCHK;
          end
        end
      end
      S_EMIT: begin
        if (PrimeReady) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // Compare before incrementing so that NumMax = all-ones ends cleanly.
        if (n_q == max_q) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NUM_W'(1);
          d_d     = (NUM_W+1)'(3);
          state_d = S_SQCHK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      min_q   <= '0;
      max_q   <= '0;
      n_q     <= '0;
      dvd_q   <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      n_q     <= n_d;
      dvd_q   <= dvd_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign Done          = (state_q == S_DONE);
  assign PrimeValid    = (state_q == S_EMIT);
  // n_q does not change while in EMIT, so PrimeNum stays stable during a stall.
  assign PrimeNum      = n_q;
  assign PrimeCount    = cnt_q;
  assign NumberChecked = n_q;

`ifdef PRIME_CYCLE_COUNT_EN
  logic [CYC_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (start_ok) begin
      cyc_d = '0;
    end else if (Busy && cyc_q != '1) begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end

  assign CycleCount = cyc_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign CycleCount      = '0;
`endif

endmodule
